spi_byte_shifter: RTL and testbench

//  SPI mode-0 byte serializer. Sits directly downstream of the SPI tx/rx data

---
 rtl/spi_byte_shifter.sv | 145 ++++++++++++++
 tb/tb_spi_byte_shifter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte serializer between the tx/rx holding register and the pins.
// Bit order: MSB first by default; define SPI_LSB_FIRST_EN for LSB first.
module spi_byte_shifter #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] clkDelay,
   input  logic [7:0]       txDataIn,
   input  logic             txDataFull,
   output logic             txDataFullClr,
   output logic [7:0]       rxDataOut,
   output logic             rxDataRdySet,
   output logic             busy,
   output logic             spiClkOut,
   output logic             spiDataOut,
   input  logic             spiDataIn
);

   typedef enum logic [1:0] {IDLE, CLK_LO, CLK_HI, DONE} state_e;

   state_e             state_q, state_d;
   logic [7:0]         shift_q, shift_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic               busy_q, busy_d;
   logic               clr_q, clr_d;
   logic               rdy_q, rdy_d;
   logic [7:0]         rx_q, rx_d;

   logic               first_bit;
   logic               next_bit;
   logic [7:0]         shift_in;

   // Sampled MISO enters at the end opposite to the outgoing bit.
`ifdef SPI_LSB_FIRST_EN
   assign first_bit = txDataIn[0];
   assign next_bit  = shift_q[0];
   assign shift_in  = {spiDataIn, shift_q[7:1]};
`else
   assign first_bit = txDataIn[7];
   assign next_bit  = shift_q[7];
   assign shift_in  = {shift_q[6:0], spiDataIn};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
         busy_q  <= 1'b0;
         clr_q   <= 1'b0;
         rdy_q   <= 1'b0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         clr_q   <= clr_d;
         rdy_q   <= rdy_d;
         rx_q    <= rx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      rx_d    = rx_q;
      clr_d   = 1'b0;
      rdy_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (txDataFull) begin
               clr_d   = 1'b1;
               shift_d = txDataIn;
               div_d   = clkDelay;
               mosi_d  = first_bit;
               busy_d  = 1'b1;
               bit_d   = '0;
               cnt_d   = '0;
               state_d = CLK_LO;
            end
         end
         CLK_LO: begin
            if (cnt_q == div_q) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               shift_d = shift_in;
               state_d = CLK_HI;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLK_HI: begin
            if (cnt_q == div_q) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (bit_q != 3'd7) begin
                  mosi_d  = next_bit;
                  bit_d   = bit_q + 3'd1;
                  state_d = CLK_LO;
               end else begin
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            rx_d    = shift_q;
            rdy_d   = 1'b1;
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign txDataFullClr = clr_q;
   assign rxDataRdySet  = rdy_q;
   assign rxDataOut     = rx_q;
   assign busy          = busy_q;
   assign spiClkOut     = sclk_q;
   assign spiDataOut    = mosi_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Scoreboard bench for spi_byte_shifter: loopback/tied MISO, timing, reset abort.
// Honours SPI_LSB_FIRST_EN for the expected MOSI bit order.
module tb_spi_byte_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] clkDelay = 8'd0;
   logic [7:0] txDataIn = 8'd0;
   logic       txDataFull = 1'b0;
   logic       txDataFullClr;
   logic [7:0] rxDataOut;
   logic       rxDataRdySet;
   logic       busy;
   logic       spiClkOut;
   logic       spiDataOut;
   logic       spiDataIn;
   logic       loop = 1'b1;

   assign spiDataIn = loop ? spiDataOut : 1'b1;

   spi_byte_shifter #(.DIV_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .clkDelay      (clkDelay),
      .txDataIn      (txDataIn),
      .txDataFull    (txDataFull),
      .txDataFullClr (txDataFullClr),
      .rxDataOut     (rxDataOut),
      .rxDataRdySet  (rxDataRdySet),
      .busy          (busy),
      .spiClkOut     (spiClkOut),
      .spiDataOut    (spiDataOut),
      .spiDataIn     (spiDataIn)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] tx;
      logic [7:0] dly;
   } txn_t;

   txn_t       tq[$];
   logic [7:0] rq[$];
   txn_t       cur;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int clr_cyc = 0;
   int rdy_cyc = 0;
   int rdy_n = 0;
   int clr_n = 0;
   int rises = 0;
   int run = 0;
   bit active = 1'b0;
   logic prev_sclk = 1'b0;
   logic prev_clr = 1'b0;
   logic prev_rdy = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_bit(input logic [7:0] b, input int k);
      logic [7:0] v;
      v = b;
`ifdef SPI_LSB_FIRST_EN
      return int'(v[k]);
`else
      return int'(v[7-k]);
`endif
   endfunction

   // One clock of observation, sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (txDataFullClr) begin
            chk("clr_w", int'(prev_clr), 0);
            chk("busy_hi", int'(busy), 1);
            chk("clr_exp", int'(tq.size() > 0), 1);
            if (tq.size() > 0) cur = tq.pop_front();
            clr_cyc = cyc;
            clr_n++;
            rises = 0;
            run = 1;
            active = 1'b1;
         end else if (spiClkOut !== prev_sclk) begin
            if (active) begin
               chk("phase", run, int'(cur.dly) + 1);
               if (spiClkOut) begin
                  chk("mosi", int'(spiDataOut), exp_bit(cur.tx, rises));
                  rises++;
               end
            end
            run = 1;
         end else begin
            run++;
         end
         if (rxDataRdySet) begin
            chk("rdy_w", int'(prev_rdy), 0);
            rdy_n++;
            rdy_cyc = cyc;
            active = 1'b0;
            chk("rx_exp", int'(rq.size() > 0), 1);
            if (rq.size() > 0) chk("rx", int'(rxDataOut), int'(rq.pop_front()));
            chk("rises", rises, 8);
            chk("span", cyc - clr_cyc, 16 * (int'(cur.dly) + 1) + 1);
            chk("mosi_idle", int'(spiDataOut), 1);
            chk("busy_lo", int'(busy), 0);
         end
      end
      prev_sclk = spiClkOut;
      prev_clr  = txDataFullClr;
      prev_rdy  = rxDataRdySet;
   endtask

   task automatic wait_clr();
      for (int i = 0; i < 200; i++) begin
         tick();
         if (txDataFullClr) break;
      end
      chk("to_clr", int'(txDataFullClr), 1);
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (rxDataRdySet) break;
      end
      chk("to_rdy", int'(rxDataRdySet), 1);
   endtask

   task automatic queue_byte(input logic [7:0] b, input logic [7:0] d);
      tq.push_back('{tx: b, dly: d});
      rq.push_back(loop ? b : 8'hFF);
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] d, input logic lp);
      loop = lp;
      clkDelay = d;
      txDataIn = b;
      queue_byte(b, d);
      txDataFull = 1'b1;
      wait_clr();
      txDataFull = 1'b0;
   endtask

   int saved;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_sclk", int'(spiClkOut), 0);
      chk("rst_mosi", int'(spiDataOut), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_clr", int'(txDataFullClr), 0);
      chk("rst_rdy", int'(rxDataRdySet), 0);
      chk("rst_rx", int'(rxDataOut), 0);
      rst = 1'b0;
      repeat (2) tick();

      // loopback, fastest clock, tx data changed after accept
      send(8'hA5, 8'd0, 1'b1);
      txDataIn = 8'h00;
      wait_rdy();
      repeat (5) tick();
      chk("rx_hold", int'(rxDataOut), 'hA5);

      // slower clock, MISO tied high
      send(8'h3C, 8'd3, 1'b0);
      wait_rdy();
      chk("clr_n", clr_n, 2);

      // back-to-back with txDataFull held across DONE
      loop = 1'b1;
      clkDelay = 8'd0;
      txDataIn = 8'h01;
      queue_byte(8'h01, 8'd0);
      txDataFull = 1'b1;
      wait_clr();
      txDataIn = 8'h80;
      queue_byte(8'h80, 8'd0);
      wait_clr();
      txDataFull = 1'b0;
      chk("b2b_gap", clr_cyc - rdy_cyc, 1);
      wait_rdy();
      chk("b2b_clr", clr_n, 4);
      chk("b2b_rdy", rdy_n, 4);

      // clkDelay change mid-byte affects only the next byte
      send(8'h5A, 8'd0, 1'b1);
      repeat (3) tick();
      clkDelay = 8'd5;
      wait_rdy();
      send(8'hC3, 8'd5, 1'b1);
      wait_rdy();

      // reset after the third SCLK rise
      send(8'hF0, 8'd0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         if (rises >= 3) break;
         tick();
      end
      chk("to_rise3", rises, 3);
      rst = 1'b1;
      tick();
      chk("ab_sclk", int'(spiClkOut), 0);
      chk("ab_mosi", int'(spiDataOut), 1);
      chk("ab_busy", int'(busy), 0);
      chk("ab_rdy", int'(rxDataRdySet), 0);
      chk("ab_rx", int'(rxDataOut), 0);
      rst = 1'b0;
      active = 1'b0;
      rq.delete();
      saved = rdy_n;
      repeat (40) tick();
      chk("ab_no_rdy", rdy_n, saved);
      chk("ab_no_clr", clr_n, 7);

      // single set bit exercises bit order
      send(8'h01, 8'd0, 1'b1);
      wait_rdy();
      chk("rx_left", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
